// File: rtl/conv_8to6.sv
// conv_8to6: reduces 4 RGBA pixels per beat from 8 to 6 bits per component,
// by truncation or 2x2 ordered dither, behind a registered output+skid buffer.
module conv_8to6 #(
  parameter int DITHER = 1,
  parameter int LW     = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [LW-1:0] line_beats,
  output logic          sink_ready,
  input  logic          sink_valid,
  input  logic          sink_sop,
  input  logic          sink_eop,
  input  logic [3:0]    sink_empty,
  input  logic [127:0]  sink_data,
  input  logic          source_ready,
  output logic          source_valid,
  output logic          source_sop,
  output logic          source_eop,
  output logic [3:0]    source_empty,
  output logic [95:0]   source_data
);

  localparam int BW = 102;

  function automatic logic [95:0] reduce_beat(input logic [127:0] din, input logic row);
    logic [95:0] res;
    logic [8:0]  sum;
    logic [1:0]  d;
    res = 96'd0;
    for (int k = 0; k < 16; k++) begin
      // column is the pixel index parity; a beat always starts on an even pixel
      case ({row, 1'(k >> 2)})
        2'b00:   d = 2'd0;
        2'b01:   d = 2'd2;
        2'b10:   d = 2'd3;
        2'b11:   d = 2'd1;
        default: d = 2'd0;
      endcase
      if (DITHER == 0) begin
        d = 2'd0;
      end else begin
        d = d;
      end
      sum = {1'b0, din[8*k +: 8]} + {7'd0, d};
      res[6*k +: 6] = sum[8] ? 6'd63 : sum[7:2];
    end
    return res;
  endfunction

  logic          or_vld_q, or_vld_d;
  logic          sk_vld_q, sk_vld_d;
  logic [BW-1:0] or_q, or_d;
  logic [BW-1:0] sk_q, sk_d;
  logic          rdy_q, rdy_d;
  logic [LW-1:0] bcnt_q, bcnt_d;
  logic [LW-1:0] lw_q, lw_d;
  logic          lpar_q, lpar_d;
  logic [LW-1:0] cur_b_s, cur_lw_s;
  logic          cur_p_s;
  logic          accept_s, emit_s;
  logic [BW-1:0] in_beat_s;

  assign accept_s  = sink_valid & rdy_q;
  assign emit_s    = or_vld_q & source_ready;
  assign cur_p_s   = sink_sop ? 1'b0 : lpar_q;
  assign cur_b_s   = sink_sop ? {LW{1'b0}} : bcnt_q;
  assign cur_lw_s  = sink_sop ? line_beats : lw_q;
  assign in_beat_s = {sink_sop, sink_eop, sink_empty, reduce_beat(sink_data, cur_p_s)};

  // Buffer next state: sink_ready is low whenever SK is full, so an accept implies SK empty.
  always_comb begin
    if (accept_s && (!or_vld_q || emit_s)) begin
      or_vld_d = 1'b1;
      or_d     = in_beat_s;
    end else if (emit_s && sk_vld_q) begin
      or_vld_d = 1'b1;
      or_d     = sk_q;
    end else if (emit_s) begin
      or_vld_d = 1'b0;
      or_d     = or_q;
    end else begin
      or_vld_d = or_vld_q;
      or_d     = or_q;
    end

    if (accept_s && or_vld_q && !emit_s) begin
      sk_vld_d = 1'b1;
      sk_d     = in_beat_s;
    end else if (emit_s) begin
      sk_vld_d = 1'b0;
      sk_d     = sk_q;
    end else begin
      sk_vld_d = sk_vld_q;
      sk_d     = sk_q;
    end

    rdy_d = ~sk_vld_d;
  end

  // Dither position: end-of-frame clears the counters ahead of the line wrap.
  always_comb begin
    bcnt_d = bcnt_q;
    lpar_d = lpar_q;
    lw_d   = lw_q;
    if (accept_s) begin
      lw_d = cur_lw_s;
      if (sink_eop) begin
        bcnt_d = {LW{1'b0}};
        lpar_d = 1'b0;
      end else if ((cur_lw_s != {LW{1'b0}}) && (cur_b_s == cur_lw_s - LW'(1))) begin
        bcnt_d = {LW{1'b0}};
        lpar_d = ~cur_p_s;
      end else begin
        bcnt_d = cur_b_s + LW'(1);
        lpar_d = cur_p_s;
      end
    end else begin
      bcnt_d = bcnt_q;
      lpar_d = lpar_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_vld_q <= 1'b0;
      sk_vld_q <= 1'b0;
      or_q     <= {BW{1'b0}};
      sk_q     <= {BW{1'b0}};
      rdy_q    <= 1'b0;
      bcnt_q   <= {LW{1'b0}};
      lw_q     <= {LW{1'b0}};
      lpar_q   <= 1'b0;
    end else begin
      or_vld_q <= or_vld_d;
      sk_vld_q <= sk_vld_d;
      or_q     <= or_d;
      sk_q     <= sk_d;
      rdy_q    <= rdy_d;
      bcnt_q   <= bcnt_d;
      lw_q     <= lw_d;
      lpar_q   <= lpar_d;
    end
  end

  assign sink_ready   = rdy_q;
  assign source_valid = or_vld_q;
  assign source_sop   = or_q[101];
  assign source_eop   = or_q[100];
  assign source_empty = or_q[99:96];
  assign source_data  = or_q[95:0];

endmodule

// File: tb/tb_conv_8to6.sv
// Scoreboard bench for conv_8to6: dithering and truncating instances share one
// stimulus stream; a reference model predicts both outputs per accepted beat.
module tb_conv_8to6;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [LW-1:0] line_beats = '0;
  logic          sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic [3:0]    sink_empty = 4'd0;
  logic [127:0]  sink_data = 128'd0;
  logic          source_ready = 1'b1;

  logic          d_ready, d_valid, d_sop, d_eop;
  logic [3:0]    d_empty;
  logic [95:0]   d_data;
  logic          t_ready, t_valid, t_sop, t_eop;
  logic [3:0]    t_empty;
  logic [95:0]   t_data;

  always #5 clk = ~clk;

  conv_8to6 #(.DITHER(1), .LW(LW)) u_dith (
    .clk(clk), .reset(reset), .line_beats(line_beats), .sink_ready(d_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_empty(sink_empty), .sink_data(sink_data), .source_ready(source_ready),
    .source_valid(d_valid), .source_sop(d_sop), .source_eop(d_eop),
    .source_empty(d_empty), .source_data(d_data));

  conv_8to6 #(.DITHER(0), .LW(LW)) u_trunc (
    .clk(clk), .reset(reset), .line_beats(line_beats), .sink_ready(t_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_empty(sink_empty), .sink_data(sink_data), .source_ready(source_ready),
    .source_valid(t_valid), .source_sop(t_sop), .source_eop(t_eop),
    .source_empty(t_empty), .source_data(t_data));

  typedef struct packed {
    logic [95:0] dd;
    logic [95:0] td;
    logic        sop;
    logic        eop;
    logic [3:0]  emp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   m_idx = 0;
  int   m_lw = 0;
  int   rmode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: per component, add the Bayer value for (row, pixel parity), saturate, divide by 4.
  function automatic logic [95:0] ref_conv(input logic [127:0] din, input int row, input bit dith);
    logic [95:0] r;
    int v, c, dv, o;
    r = 96'd0;
    for (int k = 0; k < 16; k++) begin
      v = int'(din[8*k +: 8]);
      c = (k / 4) % 2;
      if (!dith) dv = 0;
      else if (row == 0) dv = (c == 1) ? 2 : 0;
      else dv = (c == 1) ? 1 : 3;
      v = v + dv;
      o = (v > 255) ? 63 : v / 4;
      r[6*k +: 6] = 6'(o);
    end
    return r;
  endfunction

  task automatic model_push();
    exp_t e;
    int row;
    if (sink_sop) begin
      m_idx = 0;
      m_lw  = int'(line_beats);
    end
    row   = (m_lw == 0) ? 0 : ((m_idx / m_lw) % 2);
    e.dd  = ref_conv(sink_data, row, 1'b1);
    e.td  = ref_conv(sink_data, row, 1'b0);
    e.sop = sink_sop;
    e.eop = sink_eop;
    e.emp = sink_empty;
    q.push_back(e);
    m_idx = sink_eop ? 0 : m_idx + 1;
  endtask

  // Called and returns at posedge+1; the beat's output is then already presented.
  task automatic send(input logic [127:0] d, input logic s, input logic e,
                      input logic [3:0] emp, input logic [LW-1:0] lb);
    int n;
    sink_data  = d;
    sink_sop   = s;
    sink_eop   = e;
    sink_empty = emp;
    line_beats = lb;
    sink_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ready && n < 200);
    if (!d_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got sink_ready=0 expected 1 within 200 cycles");
    end else begin
      model_push();
    end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 128'(q.size()), 128'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       source_ready = 1'b1;
        1:       source_ready = 1'($urandom % 2);
        default: source_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop and compare on every transfer; check output stability while stalled.
  initial begin
    logic          held;
    logic [102:0]  prev;
    exp_t          e;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held)
          check("hold_stable", 128'({d_valid, d_sop, d_eop, d_empty, d_data}), 128'(prev));
        if (d_valid && source_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got data %0h expected no beat", d_data);
          end else begin
            e = q.pop_front();
            check("dither_data", 128'(d_data), 128'(e.dd));
            check("trunc_data", 128'(t_data), 128'(e.td));
            check("sop_eop_empty", 128'({d_sop, d_eop, d_empty}), 128'({e.sop, e.eop, e.emp}));
            check("trunc_ctrl", 128'({t_valid, t_ready, t_sop, t_eop, t_empty}),
                  128'({1'b1, d_ready, e.sop, e.eop, e.emp}));
          end
        end
        held = d_valid && !source_ready;
        prev = {d_valid, d_sop, d_eop, d_empty, d_data};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] din;
    logic [95:0]  ex;
    logic [5:0]   c;
    logic         s, e;
    int           left;

    repeat (3) @(negedge clk);
    check("rst_source_valid", 128'(d_valid), 128'd0);
    check("rst_sink_ready", 128'(d_ready), 128'd0);
    check("rst_outputs", 128'({d_sop, d_eop, d_empty, d_data}), 128'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 128'(d_ready), 128'd1);

    // one-beat frame, truncation of 0x81 gives 0x20
    din = {16{8'h81}};
    send(din, 1'b1, 1'b1, 4'h5, 12'd0);
    check("latency_valid", 128'(d_valid), 128'd1);
    ex = {16{6'h20}};
    check("trunc_0x81", 128'(t_data), 128'(ex));

    // 0x82 with two-beat lines
    din = {16{8'h82}};
    for (int b = 0; b < 4; b++) send(din, 1'(b == 0), 1'(b == 3), 4'd0, 12'd2);

    // saturation and zero on both line parities
    din = {16{8'hFF}};
    ex  = {96{1'b1}};
    send(din, 1'b1, 1'b0, 4'd0, 12'd1);
    check("sat_row0", 128'(d_data), 128'(ex));
    send(din, 1'b0, 1'b0, 4'd0, 12'd1);
    check("sat_row1", 128'(d_data), 128'(ex));
    din = 128'd0;
    send(din, 1'b0, 1'b1, 4'd0, 12'd1);
    check("zero_in", 128'(d_data), 128'd0);

    // 6->8 expansion round trip through truncation
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 16; k++) begin
        c = 6'(b * 16 + k);
        din[8*k +: 8] = {c, c[5:4]};
        ex[6*k +: 6]  = c;
      end
      send(din, 1'(b == 0), 1'(b == 3), 4'd0, 12'd0);
      check("round_trip", 128'(t_data), 128'(ex));
    end
    drain();

    // random throttled traffic
    rmode = 1;
    left  = 0;
    for (int n = 0; n < 1000; n++) begin
      if (left == 0) begin
        left = $urandom_range(1, 8);
        s = 1'b1;
      end else begin
        s = 1'b0;
      end
      e = 1'(left == 1);
      left--;
      din = {$urandom, $urandom, $urandom, $urandom};
      idle($urandom_range(0, 2));
      send(din, s, e, 4'($urandom), 12'($urandom_range(0, 4)));
      if (n % 50 == 25) begin
        @(negedge clk);
        #2;
        c[0] = d_ready;
        source_ready = ~source_ready;
        #1;
        check("ready_not_comb", 128'(d_ready), 128'(c[0]));
        source_ready = ~source_ready;
        @(posedge clk);
        #1;
      end
    end
    rmode = 0;
    drain();

    // fill OR and SK under backpressure, then reset mid-frame
    rmode = 2;
    @(posedge clk);
    #2;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 4'd1, 12'd2);
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 4'd2, 12'd2);
    check("skid_full_ready", 128'(d_ready), 128'd0);
    check("skid_full_valid", 128'(d_valid), 128'd1);
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_valid", 128'(d_valid), 128'd0);
    check("midreset_ready", 128'(d_ready), 128'd0);
    q.delete();
    m_idx = 0;
    m_lw  = 0;
    rmode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("ready_after_midreset", 128'(d_ready), 128'd1);
    send({16{8'h82}}, 1'b0, 1'b0, 4'd3, 12'd1);
    for (int b = 0; b < 3; b++) send({16{8'h82}}, 1'(b == 0), 1'(b == 2), 4'd0, 12'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
